// File: rtl/spike_current_accumulator.sv
// ============================================================================
//  Module   : spike_current_accumulator
//  Purpose  : Accumulates weighted synaptic current per target neuron from
//             spike events, then streams the currents out at end of timestep.
//             Optional macro SPIKE_SAT_CNT_EN adds a saturation event counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spike_current_accumulator #(
  parameter int NUM_NEURONS = 16,
  parameter int ID_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spike_valid,
  input  logic [ID_W-1:0]   spike_src,
  output logic              spike_ready,
  input  logic              step_end,
  output logic              w_rd_en,
  output logic [2*ID_W-1:0] w_addr,
  input  logic [16:0]       w_data,
  output logic              i_valid,
  input  logic              i_ready,
  output logic [ID_W-1:0]   i_idx,
  output logic [16:0]       i_data,
  output logic              step_done
`ifdef SPIKE_SAT_CNT_EN
  ,
  output logic [15:0]       sat_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_EMIT  = 2'd3
  } state_t;

  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_NEURONS - 1);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     src_q, src_d;
  logic [ID_W-1:0]     dst_q, dst_d;
  logic [ID_W-1:0]     idx_q, idx_d;
  logic                pend_q, pend_d;
  logic                done_q, done_d;
  logic [2*ID_W-1:0]   w_addr_q;
  logic                rd_vld_q;
  logic [ID_W-1:0]     rd_dst_q;
  logic [16:0]         acc_q [NUM_NEURONS];
  logic                emit_fire;
  logic [16:0]         add_res;

  // Sign-magnitude add, magnitude clipped to 16'hFFFF, never negative zero.
  function automatic logic [16:0] sm_add(input logic [16:0] a, input logic [16:0] b);
    logic [16:0] sum;
    logic [15:0] mag;
    logic        sgn;
    sum = '0;
    if (a[16] == b[16]) begin
      sum = {1'b0, a[15:0]} + {1'b0, b[15:0]};
      mag = sum[16] ? 16'hFFFF : sum[15:0];
      sgn = a[16];
    end else if (a[15:0] >= b[15:0]) begin
      mag = a[15:0] - b[15:0];
      sgn = a[16];
    end else begin
      mag = b[15:0] - a[15:0];
      sgn = b[16];
    end
    return {sgn && (mag != 16'h0000), mag};
  endfunction

  assign add_res = sm_add(acc_q[rd_dst_q], w_data);

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    done_d      = 1'b0;
    spike_ready = 1'b0;
    w_rd_en     = 1'b0;
    i_valid     = 1'b0;
    emit_fire   = 1'b0;
    if (step_end) pend_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        spike_ready = !pend_q;
        if (spike_valid && !pend_q) begin
          src_d   = spike_src;
          dst_d   = '0;
          state_d = S_ACCUM;
        end else if (pend_q) begin
          // Clearing here also absorbs a coincident repeated step_end.
          pend_d  = 1'b0;
          idx_d   = '0;
          state_d = S_EMIT;
        end
      end
      S_ACCUM: begin
        w_rd_en = 1'b1;
        dst_d   = dst_q + 1'b1;
        if (dst_q == LAST_IDX) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_IDLE;
      S_EMIT: begin
        i_valid = 1'b1;
        if (i_ready) begin
          emit_fire = 1'b1;
          idx_d     = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign w_addr    = (state_q == S_ACCUM) ? {src_q, dst_q} : w_addr_q;
  assign i_idx     = i_valid ? idx_q : '0;
  assign i_data    = i_valid ? acc_q[idx_q] : '0;
  assign step_done = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      idx_q    <= '0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
      w_addr_q <= '0;
      rd_vld_q <= 1'b0;
      rd_dst_q <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
      w_addr_q <= w_addr;
      rd_vld_q <= w_rd_en;
      rd_dst_q <= dst_q;
    end
  end

  // Read data lands one cycle after issue; a pending read only exists in ACCUM/DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_NEURONS; n++) acc_q[n] <= '0;
    end else if (rd_vld_q) begin
      acc_q[rd_dst_q] <= add_res;
    end else if (emit_fire) begin
      acc_q[idx_q] <= '0;
    end
  end

`ifdef SPIKE_SAT_CNT_EN
  logic [15:0] sat_cnt_q;
  logic [16:0] mag_sum;
  logic        add_clip;

  assign mag_sum   = {1'b0, acc_q[rd_dst_q][15:0]} + {1'b0, w_data[15:0]};
  assign add_clip  = (acc_q[rd_dst_q][16] == w_data[16]) && mag_sum[16];
  assign sat_count = sat_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt_q <= '0;
    end else if (rd_vld_q && add_clip && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire
